// File: rtl/accum8_ctrl.sv
// accum8_ctrl: handshaked 8-bit accumulator with ADD / SUB / LOAD / CLEAR commands.
// A command is accepted in IDLE, executed in a single EXEC cycle, and the result
// is held in DONE until downstream takes it. out_cnt counts ADD/SUB operations
// and saturates at its maximum.
// Optional build macro ACCUM8_SAT_EN: clamps out_acc on ADD carry-out (to 8'hFF)
// and SUB borrow (to 8'h00). out_carry and out_ovf always report the raw result.
module accum8_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_acc,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0]       OP_ADD   = 2'b00;
  localparam logic [1:0]       OP_SUB   = 2'b01;
  localparam logic [1:0]       OP_LOAD  = 2'b10;
  localparam logic [1:0]       OP_CLEAR = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [1:0]       op_q;
  logic [7:0]       data_q;
  logic [7:0]       acc_q;
  logic             carry_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic [8:0]       sum9;
  logic [8:0]       diff9;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       acc_nx;
  logic             carry_nx;
  logic             ovf_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             accept;

  // Handshake flags come straight from the state so they never glitch on inputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  assign out_acc   = acc_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;
  assign out_cnt   = cnt_q;

  // Next result computed from the captured command; only committed in EXEC.
  // SUB is acc + ~data + 1, so bit 8 of the sum is the no-borrow flag.
  always_comb begin
    sum9     = {1'b0, acc_q} + {1'b0, data_q};
    diff9    = {1'b0, acc_q} + {1'b0, ~data_q} + 9'd1;
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    acc_nx   = acc_q;
    carry_nx = carry_q;
    ovf_nx   = ovf_q;
    cnt_nx   = cnt_q;
    case (op_q)
      OP_ADD: begin
        carry_nx = sum9[8];
        ovf_nx   = (acc_q[7] == data_q[7]) && (sum9[7] != acc_q[7]);
        cnt_nx   = cnt_inc;
`ifdef ACCUM8_SAT_EN
        acc_nx   = sum9[8] ? 8'hFF : sum9[7:0];
`else
        acc_nx   = sum9[7:0];
`endif
      end
      OP_SUB: begin
        carry_nx = diff9[8];
        ovf_nx   = (acc_q[7] != data_q[7]) && (diff9[7] != acc_q[7]);
        cnt_nx   = cnt_inc;
`ifdef ACCUM8_SAT_EN
        acc_nx   = diff9[8] ? diff9[7:0] : 8'h00;
`else
        acc_nx   = diff9[7:0];
`endif
      end
      OP_LOAD: begin
        acc_nx   = data_q;
        carry_nx = 1'b0;
        ovf_nx   = 1'b0;
      end
      OP_CLEAR: begin
        acc_nx   = 8'h00;
        carry_nx = 1'b0;
        ovf_nx   = 1'b0;
        cnt_nx   = '0;
      end
      default: begin
        acc_nx = acc_q;
      end
    endcase
  end

  // Control FSM plus command capture and result registers; reset aborts any
  // in-flight command and clears the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_ADD;
      data_q  <= 8'h00;
      acc_q   <= 8'h00;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= in_op;
            data_q <= in_data;
            state  <= EXEC;
          end
        end
        EXEC: begin
          acc_q   <= acc_nx;
          carry_q <= carry_nx;
          ovf_q   <= ovf_nx;
          cnt_q   <= cnt_nx;
          state   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
